// File: rtl/sub_16_bit_serial.sv
// Digit-serial subtractor: input1 - input2 one DIGIT-wide slice per clock via input1 + ~input2 + 1.
// Optional signed-overflow output enabled by defining SUB16_SIGNED_OVF_EN.
module sub_16_bit_serial #(
  parameter int N     = 16,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] answer,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int NDIG = N / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_reg, b_reg;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [DIGIT:0] sum;
  logic           accept, last_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_digit = (cnt == CW'(NDIG - 1));
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One digit of the two's-complement add; top bit is the carry into the next digit.
  assign sum = {1'b0, a_reg[cnt*DIGIT +: DIGIT]} + {1'b0, b_reg[cnt*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      answer     <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      a_reg <= input1;
      b_reg <= ~input2;
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      answer[cnt*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
      carry                      <= sum[DIGIT];
      cnt                        <= cnt + CW'(1);
      if (last_digit) borrow_out <= ~sum[DIGIT];
    end
  end

`ifdef SUB16_SIGNED_OVF_EN
  logic sign1, sign2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      sign1 <= input1[N-1];
      sign2 <= input2[N-1];
    end else if (state == RUN && last_digit) begin
      // Operands of opposite sign whose result takes the subtrahend's sign.
      overflow <= (sign1 != sign2) && (sum[DIGIT-1] != sign1);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sub_16_bit_serial.sv
// Directed bench for sub_16_bit_serial: reset, latency, borrow/overflow, backpressure, abort, back-to-back.
module tb_sub_16_bit_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] input1, input2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] answer;
  logic        borrow_out;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SUB16_SIGNED_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  sub_16_bit_serial #(.N(16), .DIGIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .input1     (input1),
    .input2     (input2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .answer     (answer),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for out_valid after the accept edge; returns edges counted.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_ans, input logic exp_borrow, input logic exp_ovf);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    input1 = a; input2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; input1 = ~a; input2 = 16'h5a5a;
    wait_result(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_answer"}, answer, exp_ans);
    check({tag, "_borrow"}, borrow_out, exp_borrow);
    check({tag, "_ovf"}, overflow, exp_ovf);
    @(posedge clk); #1;
    check({tag, "_out_valid_clr"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int n_res, n_acc, last_acc;
    logic [15:0] expq[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; input1 = '0; input2 = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_answer", answer, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("basic", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    run_op("under", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    run_op("sovf",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, OVF_EN);

    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0;
    input1 = 16'hFFFF; input2 = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; input1 = 16'h0F0F; input2 = 16'h1234;
    wait_result(lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      check("bp_answer", answer, 16'h0000);
      check("bp_borrow", borrow_out, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake", out_valid, 0);
    @(posedge clk); #1;
    check("bp_single", out_valid, 0);
    check("bp_idle", in_ready, 1);

    // Reset mid-RUN aborts asynchronously.
    input1 = 16'hABCD; input2 = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_answer", answer, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("post_rst", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);

    // Back-to-back: in_valid held high, operands change every cycle.
    // Cycle i presents a = 0x0101*i, b = i, so a - b = i << 8.
    n_res = 0; n_acc = 0; last_acc = -1;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      input1 = 16'(cyc * 16'h0101);
      input2 = 16'(cyc);
      if (in_ready) begin
        if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        n_acc++;
        expq.push_back(16'(cyc << 8));
      end
      if (out_valid) begin
        n_res++;
        if (expq.size() > 0) check("b2b_answer", answer, expq.pop_front());
        else check("b2b_unexpected", 1, 0);
        check("b2b_borrow", borrow_out, 0);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("b2b_accepts", n_acc, 4);
    check("b2b_results", n_res, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_16_bit_serial.md
# sub_16_bit_serial

Digit-serial 16-bit subtractor with valid/ready handshakes on both sides. It computes `input1 - input2` one 4-bit digit per clock, using two's-complement addition (`input1 + ~input2 + 1`) with a registered carry between digits. It is the subtract counterpart to the combinational ripple adder in the datapath library, used where area matters more than latency (FPU exponent difference, address-offset checks).

## Interface
- `N`, 16, operand and result width; must be a multiple of `DIGIT`.
- `DIGIT`, 4, bits processed per clock.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `input1` input N: minuend.
- `input2` input N: subtrahend.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts result.
- `answer` output N: `(input1 - input2) mod 2^N`.
- `borrow_out` output 1: 1 iff `input1 < input2` (unsigned).
- `overflow` output 1: signed overflow; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - Accept on an edge with `in_valid`=1: latch `input1` and `~input2`, set carry=1, set digit counter=0, go to RUN.
- RUN:
  - `in_ready`=0.
  - Each edge computes digit `k` (bits `k*DIGIT+DIGIT-1 .. k*DIGIT`) as `a_k + b_k + carry`, writes the sum into `answer`, and registers the carry-out.
  - The edge that processes digit `N/DIGIT-1` moves to DONE.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - `answer`, `borrow_out` and `overflow` are held stable while `out_ready`=0.
  - The edge with `out_ready`=1 goes to IDLE and clears `out_valid`.
- `borrow_out` = NOT(final carry).
- `in_valid` and the operands are ignored outside IDLE. Only one operation is in flight; there is no overlap of a new accept with the DONE handshake.
- Operands are sampled only at the accept edge. Later changes on `input1` and `input2` have no effect.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `answer`=0, `borrow_out`=0, `overflow`=0, counter=0, carry=0.
- Latency: `out_valid` rises N/DIGIT edges after the accept edge (4 for defaults).
- Throughput: at most one result per N/DIGIT+2 cycles with `out_ready` held at 1 (accept edge, 4 RUN edges, 1 DONE handshake edge; IDLE is re-entered with `in_ready`=1 on the cycle after the handshake edge).
- Reset asserted in RUN or DONE aborts the operation immediately (asynchronous). No result is produced; outputs take their reset values.
- Intermediate `answer` bits are visible during RUN but are undefined for the consumer until `out_valid`=1.

## Configuration
- `SUB16_SIGNED_OVF_EN` defined:
  - `overflow` = (`input1[N-1]` != `input2[N-1]`) AND (`answer[N-1]` != `input1[N-1]`).
  - Registered with the final digit; valid with `out_valid`.
- `SUB16_SIGNED_OVF_EN` not defined: `overflow` is tied to 0 and the sign-bit capture registers are omitted.

## Test plan
- 0x1234 − 0x0234, `out_ready`=1 → `out_valid` 4 edges after accept; `answer`=0x1000, `borrow_out`=0, `overflow`=0.
- 0x0000 − 0x0001 → `answer`=0xFFFF, `borrow_out`=1, `overflow`=0.
- 0x8000 − 0x0001 → `answer`=0x7FFF, `borrow_out`=0; `overflow`=1 with the macro, 0 without.
- Backpressure:
  - Stimulus: 0xFFFF − 0xFFFF, `out_ready`=0 for 5 cycles after `out_valid` rises.
  - Response: `answer`=0x0000 and `borrow_out`=0 held stable, `in_ready`=0 throughout, single handshake when `out_ready` rises.
- Reset mid-RUN:
  - Stimulus: assert `rst` after 2 RUN edges.
  - Response: `out_valid`=0 and `in_ready`=1 immediately. The next operation, 0x0005 − 0x0003, gives `answer`=0x0002.
- Back-to-back: `in_valid` held at 1 with changing operands → each operation accepted only in IDLE; results match the operands present at each accept edge; 6-cycle spacing.
